// File: rtl/cart_sram_arbiter.sv
// cart_sram_arbiter: shares one PRG-RAM port between the NES CPU (absolute priority) and a host port.
// Optional per-page dirty map of CPU writes is built when CART_SRAM_DIRTY_EN is defined.
module cart_sram_arbiter #(
  parameter int ADDR_WIDTH  = 13,
  parameter int STALL_LIMIT = 64
) (
  input  logic                  clk_cpu,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_rvalid,
  output logic [7:0]            host_rdata,
  output logic                  host_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  dirty_clr,
  output logic                  dirty_any,
  output logic [ADDR_WIDTH-9:0] dirty_page
);
  localparam int PW = ADDR_WIDTH - 8;
  localparam int NP = 1 << PW;
  localparam logic [7:0] LIM = 8'(STALL_LIMIT);
  logic                  pend, p_we, cpu_rd_d, host_rd_d, issue, accept;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [7:0]            p_wdata, cpu_rdata_q, wait_cnt;
  assign host_ready  = !pend;
  assign accept      = host_valid && !pend;
  assign issue       = pend && !cpu_req;
  assign cpu_rdata   = cpu_rd_d ? mem_rdata : cpu_rdata_q;
  assign host_rvalid = host_rd_d;
  assign host_rdata  = host_rd_d ? mem_rdata : 8'h00;
  assign host_stall  = wait_cnt >= LIM;
  always_comb begin
    mem_en    = cpu_req || pend;
    mem_we    = cpu_req ? cpu_we : (pend && p_we);
    mem_addr  = cpu_req ? cpu_addr : p_addr;
    mem_wdata = cpu_req ? cpu_wdata : p_wdata;
  end
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      p_we        <= 1'b0;
      p_addr      <= '0;
      p_wdata     <= 8'h00;
      cpu_rd_d    <= 1'b0;
      host_rd_d   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      wait_cnt    <= 8'h00;
    end else begin
      cpu_rd_d  <= cpu_req && !cpu_we;
      host_rd_d <= issue && !p_we;
      if (cpu_rd_d) cpu_rdata_q <= mem_rdata;
      pend <= issue ? 1'b0 : (accept ? 1'b1 : pend);
      if (accept) begin
        p_we    <= host_we;
        p_addr  <= host_addr;
        p_wdata <= host_wdata;
      end
      wait_cnt <= issue ? 8'h00 : ((pend && wait_cnt != 8'hff) ? wait_cnt + 8'd1 : wait_cnt);
    end
  end
`ifdef CART_SRAM_DIRTY_EN
  logic [NP-1:0] map, map_n;
  logic [PW-1:0] low;
  // A CPU write coinciding with dirty_clr survives the clear
  always_comb begin
    map_n = (dirty_clr ? '0 : map) |
            ((cpu_req && cpu_we) ? ({{(NP-1){1'b0}}, 1'b1} << cpu_addr[ADDR_WIDTH-1:8]) : '0);
    low = '0;
    for (int i = NP - 1; i >= 0; i--) if (map_n[i]) low = i[PW-1:0];
  end
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      map        <= '0;
      dirty_any  <= 1'b0;
      dirty_page <= '0;
    end else begin
      map        <= map_n;
      dirty_any  <= |map_n;
      dirty_page <= low;
    end
  end
`else
  logic unused_dirty_clr;
  assign unused_dirty_clr = dirty_clr;
  assign dirty_any  = 1'b0;
  assign dirty_page = '0;
`endif
endmodule

// File: tb/tb_cart_sram_arbiter.sv
// tb_cart_sram_arbiter: directed and randomized stimulus against a transaction-level reference model.
module tb_cart_sram_arbiter;
  localparam int AW  = 13;
  localparam int LIM = 4;
  localparam int NPG = 1 << (AW - 8);
  logic clk_cpu = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, host_valid = 1'b0, host_we = 1'b0, dirty_clr = 1'b0;
  logic [AW-1:0] cpu_addr = '0, host_addr = '0;
  logic [7:0] cpu_wdata = 8'h00, host_wdata = 8'h00;
  logic [7:0] cpu_rdata, host_rdata, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic host_ready, host_rvalid, host_stall, mem_en, mem_we, dirty_any;
  logic [AW-1:0] mem_addr;
  logic [AW-9:0] dirty_page;

  cart_sram_arbiter #(.ADDR_WIDTH(AW), .STALL_LIMIT(LIM)) dut (
    .clk_cpu(clk_cpu), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_stall(host_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dirty_clr(dirty_clr), .dirty_any(dirty_any), .dirty_page(dirty_page)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Environment RAM: single port, synchronous read
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk_cpu)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  // Reference model state
  logic [7:0] ref_mem [0:(1<<AW)-1];
  bit pend, pend_we, exp_rv;
  logic [AW-1:0] pend_addr;
  logic [7:0] pend_wdata, exp_rdata, exp_cpu;
  int waited;
  bit [NPG-1:0] map;
  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input bit rq, input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                      input bit hv, input bit hwe, input logic [AW-1:0] ha, input logic [7:0] hd,
                      input bit clr, input bit rn);
    bit issue, accept, e_any;
    int e_page;
    @(negedge clk_cpu);
    cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hd;
    dirty_clr = clr; rst_n = rn;
    #1;
    if (!rn) begin
      pend = 0; waited = 0; exp_rv = 0; exp_cpu = 8'h00; map = '0;
    end
    check("host_ready", host_ready, !pend);
    check("host_rvalid", host_rvalid, exp_rv);
    if (exp_rv) check("host_rdata", host_rdata, exp_rdata);
    if (!rn) check("host_rdata_rst", host_rdata, 8'h00);
    check("cpu_rdata", cpu_rdata, exp_cpu);
    check("host_stall", host_stall, waited >= LIM);
    check("mem_en", mem_en, rq || pend);
    if (rq) begin
      check("mem_we_cpu", mem_we, we);
      check("mem_addr_cpu", mem_addr, a);
      if (we) check("mem_wdata_cpu", mem_wdata, d);
    end else if (pend) begin
      check("mem_we_host", mem_we, pend_we);
      check("mem_addr_host", mem_addr, pend_addr);
      if (pend_we) check("mem_wdata_host", mem_wdata, pend_wdata);
    end else check("mem_we_idle", mem_we, 0);
    e_any = 0; e_page = 0;
`ifdef CART_SRAM_DIRTY_EN
    e_any = |map;
    for (int i = NPG - 1; i >= 0; i--) if (map[i]) e_page = i;
`endif
    check("dirty_any", dirty_any, e_any);
    check("dirty_page", dirty_page, e_page);
    issue = pend && !rq;
    accept = hv && !pend && rn;
    exp_rv = issue && !pend_we;
    if (exp_rv) exp_rdata = ref_mem[pend_addr];
    if (rq && we) ref_mem[a] = d;
    if (rq && !we && rn) exp_cpu = ref_mem[a];
    if (issue) begin
      if (pend_we) ref_mem[pend_addr] = pend_wdata;
      pend = 0; waited = 0;
    end else if (pend) waited = (waited < 255) ? waited + 1 : 255;
    if (accept) begin
      pend = 1; pend_we = hwe; pend_addr = ha; pend_wdata = hd;
    end
    if (rn) begin
      if (clr) map = '0;
      if (rq && we) map[a[AW-1:8]] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 8'h00, 0, 0, '0, 8'h00, 0, 1);
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 63)) : AW'($urandom);
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    pend = 0; pend_we = 0; pend_addr = '0; pend_wdata = 8'h00;
    exp_rv = 0; exp_rdata = 8'h00; exp_cpu = 8'h00; waited = 0; map = '0;
    step(1, 1, 13'h0005, 8'h33, 0, 0, '0, 8'h00, 0, 0);
    step(0, 0, '0, 8'h00, 0, 0, '0, 8'h00, 0, 0);
    idle(1);
    // CPU write then read back
    step(1, 1, 13'h0010, 8'h5A, 0, 0, '0, 8'h00, 0, 1);
    step(1, 0, 13'h0010, 8'h00, 0, 0, '0, 8'h00, 0, 1);
    idle(1);
    check("rd_0010", cpu_rdata, 8'h5A);
    // Host read held off by three CPU cycles
    step(1, 0, 13'h0001, 8'h00, 1, 0, 13'h0100, 8'h00, 0, 1);
    step(1, 0, 13'h0002, 8'h00, 0, 0, '0, 8'h00, 0, 1);
    step(1, 0, 13'h0003, 8'h00, 0, 0, '0, 8'h00, 0, 1);
    step(0, 0, '0, 8'h00, 0, 0, '0, 8'h00, 0, 1);
    step(0, 0, '0, 8'h00, 0, 0, '0, 8'h00, 0, 1);
    check("rvalid_0100", host_rvalid, 1);
    idle(1);
    // Stall threshold
    step(1, 1, 13'h0020, 8'h01, 1, 1, 13'h0021, 8'h77, 0, 1);
    for (int k = 0; k < 6; k++) step(1, 0, 13'h0030, 8'h00, 0, 0, '0, 8'h00, 0, 1);
    check("stall_hi", host_stall, 1);
    idle(2);
    check("stall_lo", host_stall, 0);
    // Same-address ordering: CPU write then queued host write
    step(1, 1, 13'h0040, 8'h11, 1, 1, 13'h0040, 8'h22, 0, 1);
    idle(1);
    step(1, 0, 13'h0040, 8'h00, 0, 0, '0, 8'h00, 0, 1);
    idle(1);
    check("order_0040", cpu_rdata, 8'h22);
    // Dirty map clear race
    step(1, 1, 13'h1234, 8'h9C, 0, 0, '0, 8'h00, 1, 1);
    idle(1);
    step(0, 0, '0, 8'h00, 0, 0, '0, 8'h00, 1, 1);
    idle(1);
    // Wait counter saturation
    step(1, 0, 13'h0007, 8'h00, 1, 0, 13'h0200, 8'h00, 0, 1);
    for (int k = 0; k < 300; k++) step(1, 0, raddr(), 8'h00, 0, 0, '0, 8'h00, 0, 1);
    idle(3);
    // Reset with a host read pending
    step(1, 0, 13'h0008, 8'h00, 1, 0, 13'h0300, 8'h00, 0, 1);
    step(1, 0, 13'h0009, 8'h00, 0, 0, '0, 8'h00, 0, 1);
    step(0, 0, '0, 8'h00, 0, 0, '0, 8'h00, 0, 0);
    step(0, 0, '0, 8'h00, 0, 0, '0, 8'h00, 0, 0);
    idle(3);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    // Randomized traffic with varying CPU load
    for (int k = 0; k < 4000; k++) begin
      int load;
      load = (k / 500) % 4;
      step($urandom_range(0, 3) < load, $urandom_range(0, 1), raddr(), 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1), raddr(), 8'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 999) != 0);
    end
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cart_sram_arbiter.md
CART_SRAM_ARBITER -- requirements
Module: cart_sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, PRG-RAM byte-address width (8 KiB).
REQ-002 SHALL have parameter STALL_LIMIT, default 64, host wait cycles before host_stall asserts; range 1..255.
REQ-003 SHALL have clk_cpu  in  1  the only clock; all logic is on its rising edge.
REQ-004 SHALL have rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have cpu_req  in  1  NES CPU accesses PRG-RAM this cycle.
REQ-006 SHALL have cpu_we  in  1  CPU write when high, read when low.
REQ-007 SHALL have cpu_addr  in  ADDR_WIDTH  CPU byte address.
REQ-008 SHALL have cpu_wdata  in  8  CPU write data.
REQ-009 SHALL have cpu_rdata  out  8  CPU read data.
REQ-010 SHALL have host_valid/host_ready  in/out  1/1  host request handshake.
REQ-011 SHALL have host_we, host_addr, host_wdata  in  1/ADDR_WIDTH/8  host request fields.
REQ-012 SHALL have host_rvalid, host_rdata  out  1/8  host read response.
REQ-013 SHALL have host_stall  out  1  pending host request waited at least STALL_LIMIT cycles.
REQ-014 SHALL have mem_en, mem_we, mem_addr, mem_wdata  out  1/1/ADDR_WIDTH/8  single RAM port, synchronous read, 1-cycle latency.
REQ-015 SHALL have mem_rdata  in  8  RAM read data.
REQ-016 SHALL have dirty_clr  in  1  pulse; clears dirty map.
REQ-017 SHALL have dirty_any, dirty_page  out  1/(ADDR_WIDTH-8)  dirty status.

Function
REQ-018 CPU SHALL have absolute priority: when cpu_req=1, mem_* SHALL carry the CPU access combinationally in the same cycle.
REQ-019 CPU read issued in cycle N: cpu_rdata SHALL equal mem_rdata from N+1 and be held until the next CPU read completes.
REQ-020 Host side SHALL use a one-entry pending register; host_ready = !pending; accept on host_valid & host_ready.
REQ-021 Accepted request SHALL NOT issue in its acceptance cycle; it SHALL issue in the first later cycle with cpu_req=0, clearing pending on that edge.
REQ-022 Issued host read SHALL pulse host_rvalid for one cycle at issue+1, with host_rdata = mem_rdata; host writes produce no response.
REQ-023 With mem_en low (no CPU, no pending), mem_we SHALL be 0 and address/data are don't-care.
REQ-024 Wait counter SHALL count cycles pending=1 without issue, saturate at 255, clear on issue; host_stall = (counter >= STALL_LIMIT).
REQ-025 Back-to-back host traffic SHALL reach one request per two cycles at best (accept, issue); host_ready rises the cycle after issue.
REQ-026 CPU write and pending host write to the same address SHALL execute in order: CPU first, host later, so host data is final.

Reset
REQ-027 While rst_n=0, SHALL force: pending=0, host_ready=1, host_rvalid=0, host_rdata=0, cpu_rdata=0, host_stall=0, counter=0, dirty map clear, dirty_any=0, dirty_page=0; mem_en/mem_we follow cpu_req/cpu_we only.
REQ-028 Reset asserted mid-operation SHALL drop the pending request with no response; no host_rvalid after reset release.

Configuration
REQ-029 Macro CART_SRAM_DIRTY_EN defined: SHALL keep a 2^(ADDR_WIDTH-8)-bit map of 256-byte pages; a CPU write sets bit cpu_addr[ADDR_WIDTH-1:8]; host writes never set bits.
REQ-030 With macro: dirty_clr clears all bits; CPU write in the same cycle as dirty_clr leaves its page set; dirty_any = OR of map; dirty_page = lowest set index, 0 if none; outputs registered, one cycle after the write.
REQ-031 Macro undefined: no map logic; dirty_any=0, dirty_page=0, dirty_clr ignored.

Verification
REQ-032 CPU write 0x5A to 0x0010, then CPU read of 0x0010 -> cpu_rdata=0x5A one cycle after the read.
REQ-033 Host read 0x0100 accepted while cpu_req=1 for 3 cycles -> issue on cycle 4, host_rvalid pulses on cycle 5, host_ready=0 throughout.
REQ-034 STALL_LIMIT=4, host pending with cpu_req=1 for 6 cycles -> host_stall=1 from the 4th wait cycle and cleared after issue.
REQ-035 CART_SRAM_DIRTY_EN: CPU write 0x1234 and dirty_clr in the same cycle -> dirty_any=1, dirty_page=0x12; next dirty_clr alone -> dirty_any=0.
REQ-036 rst_n low while host read pending -> host_ready=1 and no host_rvalid after release; cpu_rdata=0.
REQ-037 CPU write 0x11 and queued host write 0x22 to 0x0040 -> subsequent read returns 0x22.
